// File: rtl/sar_result_capture.sv
// sar_result_capture
//   Return-path companion to count_monitor in the SAR ADC loop. Watches the
//   sample/comp_en timing and the comparator outputs, assembles an NBITS-bit
//   conversion code MSB-first, and buffers finished codes in a small show-ahead
//   FIFO behind a valid/ready port.
//
// Ports
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   sample     in   1        sampling phase (async)
//   comp_en    in   1        comparator strobe, one decision per high pulse (async)
//   comp_p     in   1        comparator positive output (async)
//   comp_n     in   1        comparator negative output (async)
//   out_data   out  NBITS+1  {err, code} at FIFO head, 0 when empty
//   out_valid  out  1        FIFO non-empty
//   out_ready  in   1        host accepts head when out_valid & out_ready
//   busy       out  1        capture FSM not idle
//   overrun    out  8        saturating count of results dropped on a full FIFO
//   aborts     out  8        saturating count of conversions cut short by sample
module sar_result_capture #(
  parameter int NBITS       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic             comp_en,
  input  logic             comp_p,
  input  logic             comp_n,
  output logic [NBITS:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       overrun,
  output logic [7:0]       aborts
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  // Synchronizers: {sample, comp_en, comp_p, comp_n} travel together so a
  // decision sees comparator levels aligned with its own strobe.
  logic [3:0] sync_q [SYNC_STAGES];
  logic       s_sample, s_comp_en, s_comp_p, s_comp_n, s_comp_en_q;
  logic       strobe, dbit, unresolved;

  state_t            state, state_nx;
  logic              do_clear, do_bit, do_abort, push;
  logic [IW-1:0]     idx;
  logic [NBITS-1:0]  shreg;
  logic              err;

  logic [NBITS:0]    mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic              full, pop, wr, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_comp_en_q <= 1'b0;
    end else begin
      sync_q[0] <= {sample, comp_en, comp_p, comp_n};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_comp_en_q <= s_comp_en;
    end
  end

  assign s_sample   = sync_q[SYNC_STAGES-1][3];
  assign s_comp_en  = sync_q[SYNC_STAGES-1][2];
  assign s_comp_p   = sync_q[SYNC_STAGES-1][1];
  assign s_comp_n   = sync_q[SYNC_STAGES-1][0];
  assign strobe     = s_comp_en & ~s_comp_en_q;
  assign dbit       = s_comp_p & ~s_comp_n;
  assign unresolved = ~(s_comp_p ^ s_comp_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_clear = 1'b0;
    do_bit   = 1'b0;
    do_abort = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (s_sample) state_nx = SAMPLE;
      end
      SAMPLE: begin
        do_clear = 1'b1;
        if (!s_sample) state_nx = CONVERT;
      end
      CONVERT: begin
        // A sample rise beats a coincident strobe: the bit is never written.
        if (s_sample) begin
          do_abort = 1'b1;
          state_nx = SAMPLE;
        end else if (strobe) begin
          do_bit = 1'b1;
          if (idx == '0) state_nx = DONE;
        end
      end
      DONE: begin
        push     = 1'b1;
        state_nx = s_sample ? SAMPLE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= IW'(NBITS - 1);
      shreg  <= '0;
      err    <= 1'b0;
      aborts <= '0;
    end else begin
      if (do_clear) begin
        idx   <= IW'(NBITS - 1);
        shreg <= '0;
        err   <= 1'b0;
      end else if (do_bit) begin
        shreg[idx] <= dbit;
        err        <= err | unresolved;
        if (idx != '0) idx <= idx - 1'b1;
      end
      if (do_abort && aborts != 8'hFF) aborts <= aborts + 8'd1;
    end
  end

  // Result FIFO. When full, a push still succeeds if the head leaves in the
  // same cycle: the write lands in the slot being vacated (wptr == rptr).
  assign full      = (count == (PW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign wr        = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_data  = out_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= {err, shreg};
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (wr && !pop)      count <= count + 1'b1;
      else if (pop && !wr) count <= count - 1'b1;
      if (drop && overrun != 8'hFF) overrun <= overrun + 8'd1;
    end
  end

endmodule

// File: tb/tb_sar_result_capture.sv
module tb_sar_result_capture;

  localparam int NBITS = 6;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sample, comp_en, comp_p, comp_n;
  logic [NBITS:0]   out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [7:0]       overrun, aborts;

  sar_result_capture #(.NBITS(NBITS), .SYNC_STAGES(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .comp_en(comp_en),
    .comp_p(comp_p), .comp_n(comp_n), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .overrun(overrun), .aborts(aborts)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  int exp_over   = 0;
  int exp_aborts = 0;
  logic [NBITS:0] exp_q [$];

  bit ready_mode  = 1'b0;   // 1: random out_ready each cycle
  bit ready_force = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: each decision independently gives 1 (p&~n), 0 (~p&n) or an
  // unresolved 0 that sets the sticky error flag.
  function automatic logic [NBITS:0] ref_code(input logic [NBITS-1:0] p, input logic [NBITS-1:0] n);
    int code = 0;
    bit e = 1'b0;
    for (int b = 0; b < NBITS; b++) begin
      if (p[b] == n[b]) e = 1'b1;
      else if (p[b])    code += (1 << b);
    end
    return {e, NBITS'(code)};
  endfunction

  task automatic rand_pn(output logic [NBITS-1:0] p, output logic [NBITS-1:0] n);
    for (int b = 0; b < NBITS; b++) begin
      p[b] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) n[b] = p[b];
      else                           n[b] = ~p[b];
    end
  endtask

  // nstr < NBITS: only nstr strobes, then sample rises (abort). With sca set the
  // next strobe rises together with sample.
  task automatic conv(input logic [NBITS-1:0] p, input logic [NBITS-1:0] n, input int nstr,
                      input bit sca, input bit ready_pulse, input logic [NBITS:0] expv);
    sample = 1'b1;
    step(4);
    sample = 1'b0;
    step(3);
    for (int b = 0; b < nstr; b++) begin
      comp_p  = p[NBITS-1-b];
      comp_n  = n[NBITS-1-b];
      comp_en = 1'b1;
      if (b == NBITS-1) begin
        step(3);                       // DONE cycle begins here
        if (ready_pulse) ready_force = 1'b1;
        step(1);                       // FIFO write edge just passed
        if (ready_pulse) ready_force = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(expv);
        else if (exp_over < 255) exp_over++;
        comp_en = 1'b0;
        step(2);
      end else begin
        step(3);
        comp_en = 1'b0;
        step(2);
      end
    end
    if (nstr < NBITS) begin
      if (sca) begin
        comp_p  = p[NBITS-1-nstr];
        comp_n  = n[NBITS-1-nstr];
        comp_en = 1'b1;
      end
      sample = 1'b1;
      if (exp_aborts < 255) exp_aborts++;
      step(3);
      comp_en = 1'b0;
      step(1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit             hold_q = 1'b0;
    logic [NBITS:0] hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_q = 1'b0;
      end else begin
        if (hold_q) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hold_d);
        end
        chk("valid_vs_model", out_valid, exp_q.size() != 0);
        if (!out_valid) chk("empty_data", out_data, 0);
        if (out_valid && out_ready && exp_q.size() != 0) begin
          chk("pop_data", out_data, exp_q.pop_front());
          pops++;
        end
        hold_q = out_valid & ~out_ready;
        hold_d = out_data;
      end
    end
  end

  initial begin
    logic [NBITS-1:0] p, n;
    int pops0;
    bit last_partial;
    rst_n = 1'b0; sample = 1'b0; comp_en = 1'b0; comp_p = 1'b0; comp_n = 1'b0;
    out_ready = 1'b0;
    step(2);

    // Reset held with activity on the inputs
    sample = 1'b1;
    for (int i = 0; i < 6; i++) begin
      comp_en = ~comp_en;
      comp_p  = ~comp_p;
      step(1);
    end
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_aborts", aborts, 0);
    sample = 1'b0; comp_en = 1'b0; comp_p = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(4);
    chk("idle_busy", busy, 0);

    // Basic conversion, then unresolved 3rd decision
    ready_force = 1'b1;
    conv(6'b101101, 6'b010010, NBITS, 0, 0, 7'b0_101101);
    chk("conv_busy_done", busy, 0);
    conv(6'b111101, 6'b011010, NBITS, 0, 0, 7'b1_100101);
    chk("unres_busy_done", busy, 0);

    // Abort after 3 strobes, then all-ones
    conv(6'b101101, 6'b010010, 3, 0, 0, '0);
    step(2);
    chk("abort_cnt", aborts, 1);
    chk("abort_busy", busy, 1);
    conv(6'b111111, 6'b000000, NBITS, 0, 0, 7'b0_111111);
    step(4);
    chk("abort_no_extra_pop", pops, 3);

    // Backpressure: 6 conversions into a 4-deep FIFO
    ready_force = 1'b0;
    step(2);
    for (int i = 0; i < 6; i++) begin
      rand_pn(p, n);
      conv(p, n, NBITS, 0, 0, ref_code(p, n));
    end
    chk("bp_overrun", overrun, 2);
    chk("bp_valid", out_valid, 1);
    pops0 = pops;
    ready_force = 1'b1;
    step(10);
    chk("bp_drained", pops - pops0, 4);
    chk("bp_empty", out_valid, 0);

    // Full FIFO, push and pop in the DONE cycle
    ready_force = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) begin
      rand_pn(p, n);
      conv(p, n, NBITS, 0, 0, ref_code(p, n));
    end
    rand_pn(p, n);
    pops0 = pops;
    conv(p, n, NBITS, 0, 1, ref_code(p, n));
    chk("pp_overrun", overrun, 2);
    chk("pp_one_pop", pops - pops0, 1);
    ready_force = 1'b1;
    step(10);
    chk("pp_drained", pops - pops0, 5);
    chk("pp_empty", out_valid, 0);

    // Same-cycle strobe and sample rise: abort, bit discarded
    conv(6'b111111, 6'b000000, 2, 1, 0, '0);
    step(2);
    chk("sca_aborts", aborts, 2);
    conv(6'b000001, 6'b111110, NBITS, 0, 0, 7'b0_000001);

    // Randomized traffic with random backpressure and occasional aborts
    ready_mode = 1'b1;
    last_partial = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rand_pn(p, n);
      if ($urandom_range(0, 7) == 0) begin
        conv(p, n, $urandom_range(1, NBITS-1), 1'($urandom_range(0, 1)), 0, '0);
        last_partial = 1'b1;
      end else begin
        conv(p, n, NBITS, 0, 0, ref_code(p, n));
        last_partial = 1'b0;
      end
    end
    if (last_partial) begin
      rand_pn(p, n);
      conv(p, n, NBITS, 0, 0, ref_code(p, n));
    end
    ready_mode = 1'b0;
    ready_force = 1'b1;
    step(12);
    chk("rand_overrun", overrun, exp_over);
    chk("rand_aborts", aborts, exp_aborts);
    chk("rand_empty", out_valid, 0);
    chk("rand_busy", busy, 0);

    // Reset mid-conversion with results pending
    ready_force = 1'b0;
    step(2);
    for (int i = 0; i < 2; i++) begin
      rand_pn(p, n);
      conv(p, n, NBITS, 0, 0, ref_code(p, n));
    end
    sample = 1'b1; step(4);
    sample = 1'b0; step(3);
    comp_p = 1'b1; comp_n = 1'b0; comp_en = 1'b1;
    step(3);
    rst_n = 1'b0;
    exp_q.delete();
    exp_over = 0;
    exp_aborts = 0;
    step(1);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_aborts", aborts, 0);
    chk("mrst_overrun", overrun, 0);
    comp_en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    ready_force = 1'b1;
    conv(6'b110011, 6'b001100, NBITS, 0, 0, 7'b0_110011);
    step(4);
    chk("post_rst_empty", out_valid, 0);
    chk("post_rst_aborts", aborts, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
